gray_count_source: RTL and testbench

- Sequential Gray-code sequence generator that sits directly upstream of the 4-bit Gray-to-binary converter and feeds its gray input.
- Holds a binary count and presents its Gray encoding as a registered stream with valid/ready handshake.
- Supports up/down counting, synchronous load and a wrap pulse.
- Used to drive converter regression and produce ML training-data sequences.

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_step_checker.sv | 44 ++++
 rtl/gray_count_source.sv | 105 ++++++++++
 tb/tb_gray_count_source.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code count source and its step checker.
package gray_pkg;

   localparam int GRAY_DEFAULT_WIDTH = 4;
   localparam int GRAY_MAX_WIDTH     = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } gen_state_e;

   // Callers zero-extend into and truncate out of the wide form to stay width-generic.
   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Flags any pair of consecutively accepted beats that do not differ in exactly one bit.
// The flag is sticky until reset; a load restarts the comparison.
module gray_step_checker
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] beat,
   input  logic             accept,
   input  logic             restart,
   output logic             gray_err
);

   logic [WIDTH-1:0] prevBeat;
   logic             havePrev;
   logic             stepBad;

   assign stepBad = havePrev && ($countones(beat ^ prevBeat) != 1);

   // A restart in the same cycle as an accept still drops the history, so the
   // loaded value is never compared with the beat it replaces.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prevBeat <= '0;
         havePrev <= 1'b0;
         gray_err <= 1'b0;
      end else begin
         if (accept) begin
            prevBeat <= beat;
            if (stepBad) begin
               gray_err <= 1'b1;
            end
         end
         if (restart) begin
            havePrev <= 1'b0;
         end else if (accept) begin
            havePrev <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/gray_count_source.sv
// Gray-code beat source with valid/ready handshake, up/down count, load and wrap pulse.
// Optional GRAY_STEP_CHECK_EN adds a sticky gray_err output from a step checker.
module gray_count_source
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
`ifdef GRAY_STEP_CHECK_EN
   ,
   output logic             gray_err
`endif
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   gen_state_e       state, nextState;
   logic [WIDTH-1:0] cnt, nextCnt, nextGray;
   logic             nextWrap;
   logic             handshake;
   logic             loadTaken;

   assign out_valid = (state != IDLE);
   assign handshake = out_valid && out_ready;

   // STALL differs from RUN only in name: both present the held beat until accepted.
   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      nextWrap  = 1'b0;
      loadTaken = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               nextCnt   = load_bin;
               loadTaken = 1'b1;
            end
            if (en) begin
               nextState = RUN;
            end
         end
         RUN, STALL: begin
            if (handshake) begin
               if (load) begin
                  nextCnt   = load_bin;
                  loadTaken = 1'b1;
               end else if (up_dn) begin
                  nextCnt  = cnt + 1'b1;
                  nextWrap = (cnt == ALL_ONES);
               end else begin
                  nextCnt  = cnt - 1'b1;
                  nextWrap = (cnt == '0);
               end
               nextState = en ? RUN : IDLE;
            end else begin
               nextState = STALL;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
      nextGray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(nextCnt)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         gray  <= '0;
         wrap  <= 1'b0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
         gray  <= nextGray;
         wrap  <= nextWrap;
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   gray_step_checker #(
      .WIDTH(WIDTH)
   ) u_step_checker (
      .clk      (clk),
      .rst_n    (rst_n),
      .beat     (gray),
      .accept   (handshake),
      .restart  (loadTaken),
      .gray_err (gray_err)
   );
`else
   logic unusedLoadTaken;
   assign unusedLoadTaken = loadTaken;
`endif

endmodule

// File: tb/tb_gray_count_source.sv
// Directed self-checking bench for gray_count_source at WIDTH=4.
// Optional GRAY_STEP_CHECK_EN section exercises the sticky gray_err output.
module tb_gray_count_source;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_bin;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] gray;
   logic             wrap;
`ifdef GRAY_STEP_CHECK_EN
   logic             gray_err;
`endif

   int checkCount;
   int errorCount;

   gray_count_source #(
      .WIDTH(WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .up_dn     (up_dn),
      .load      (load),
      .load_bin  (load_bin),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .gray      (gray),
      .wrap      (wrap)
`ifdef GRAY_STEP_CHECK_EN
      ,
      .gray_err  (gray_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checkCount++;
      if (got !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
      end
   endtask

   task automatic applyStimulus(input logic enV, input logic upV, input logic loadV,
                                input logic [WIDTH-1:0] binV, input logic readyV);
      en        = enV;
      up_dn     = upV;
      load      = loadV;
      load_bin  = binV;
      out_ready = readyV;
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] freeRunExp [17] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
      4'b0000
   };

   initial begin
      checkCount = 0;
      errorCount = 0;

      // Reset held for two clocks with en high
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      waitCycle();
      waitCycle();
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_gray", 32'(gray), 32'd0);
      checkOutput("reset_wrap", 32'(wrap), 32'd0);

      rst_n = 1'b1;
      waitCycle();
      checkOutput("first_valid", 32'(out_valid), 32'd1);
      checkOutput("first_gray", 32'(gray), 32'(freeRunExp[0]));

      // Free-run up with downstream always ready
      for (int i = 1; i < 17; i++) begin
         waitCycle();
         checkOutput($sformatf("run_gray_%0d", i), 32'(gray), 32'(freeRunExp[i]));
         checkOutput($sformatf("run_valid_%0d", i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("run_wrap_%0d", i), 32'(wrap), (i == 16) ? 32'd1 : 32'd0);
      end
      waitCycle();
      checkOutput("post_wrap_gray", 32'(gray), 32'b0001);
      checkOutput("post_wrap_wrap", 32'(wrap), 32'd0);
      waitCycle();
      checkOutput("pre_stall_gray", 32'(gray), 32'b0011);

      // Backpressure: gray held; dropping en mid-stall has no effect
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         waitCycle();
         checkOutput($sformatf("stall_gray_%0d", i), 32'(gray), 32'b0011);
         checkOutput($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'd1);
         en = 1'b0;
      end
      out_ready = 1'b1;
      waitCycle();
      checkOutput("release_valid", 32'(out_valid), 32'd0);
      checkOutput("release_gray", 32'(gray), 32'b0010);

      // Load in IDLE: 1010 -> Gray 1111, then 1110 counting up
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b1010, 1'b1);
      waitCycle();
      checkOutput("load_idle_gray", 32'(gray), 32'b1111);
      checkOutput("load_idle_valid", 32'(out_valid), 32'd1);
      load = 1'b0;
      waitCycle();
      checkOutput("load_next_gray", 32'(gray), 32'b1110);

      // Load during STALL is ignored
      out_ready = 1'b0;
      waitCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
      waitCycle();
      checkOutput("stall_load_gray", 32'(gray), 32'b1110);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      waitCycle();
      checkOutput("stall_load_after", 32'(gray), 32'b1010);

      // Load 0000 in a handshake cycle, then count down through the wrap
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000, 1'b1);
      waitCycle();
      checkOutput("down_load_gray", 32'(gray), 32'b0000);
      checkOutput("down_load_wrap", 32'(wrap), 32'd0);
      load = 1'b0;
      waitCycle();
      checkOutput("down_wrap_gray", 32'(gray), 32'b1000);
      checkOutput("down_wrap_pulse", 32'(wrap), 32'd1);
      waitCycle();
      checkOutput("down_next_gray", 32'(gray), 32'b1001);
      checkOutput("down_next_wrap", 32'(wrap), 32'd0);

      // Reset mid-operation drops the pending beat
      rst_n = 1'b0;
      waitCycle();
      checkOutput("midreset_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset_gray", 32'(gray), 32'd0);
      rst_n = 1'b1;
      en    = 1'b0;
      waitCycle();
      checkOutput("idle_hold_valid", 32'(out_valid), 32'd0);

`ifdef GRAY_STEP_CHECK_EN
      // Clean run keeps gray_err low; a forced count jump sets it until reset
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      waitCycle();
      waitCycle();
      waitCycle();
      checkOutput("chk_clean", 32'(gray_err), 32'd0);
      dut.cnt = 4'd6;
      waitCycle();
      waitCycle();
      checkOutput("chk_set", 32'(gray_err), 32'd1);
      waitCycle();
      waitCycle();
      checkOutput("chk_sticky", 32'(gray_err), 32'd1);
      rst_n = 1'b0;
      waitCycle();
      checkOutput("chk_reset", 32'(gray_err), 32'd0);
      rst_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
